// File: rtl/stream_lifo.sv
// Valid/ready LIFO stack of DEPTH samples; the newest sample is presented first on out_data.
// Latency: 1 cycle from push to visibility. Backpressure: in_ready = !full, outputs depend on registers only.
// Optional STREAM_LIFO_DRAIN_EN: alternate fill/drain phases so each DEPTH block is emitted reversed.
module stream_lifo #(
    parameter int  DATA_WIDTH = 16,
    parameter int  DEPTH      = 8,
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty
);

    localparam int                   IDX_W    = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  push;
    logic                  pop;
    logic [IDX_W-1:0]      top_idx;
    logic [IDX_W-1:0]      wr_idx;

    assign count = cnt_q;
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);

`ifdef STREAM_LIFO_DRAIN_EN
    typedef enum logic {FILL, DRAIN} phase_t;
    phase_t state_q;
    phase_t state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (push && (cnt_q == FULL_CNT - ONE)) state_d = DRAIN;
            DRAIN:   if (pop && (cnt_q == ONE))             state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            FILL:    in_ready  = !full;
            DRAIN:   out_valid = !empty;
            default: ;
        endcase
    end
`else
    assign in_ready  = !full;
    assign out_valid = !empty;
`endif

    assign push    = in_valid && in_ready;
    assign pop     = out_valid && out_ready;
    assign top_idx = IDX_W'(cnt_q - ONE);
    // A simultaneous push and pop replaces the current top in place.
    assign wr_idx  = pop ? top_idx : IDX_W'(cnt_q);

    assign out_data = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + ONE;
                2'b01:   cnt_q <= cnt_q - ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule
